// File: rtl/spatial_encoder_param.sv
// -----------------------------------------------------------------------------
// spatial_encoder_param
// Parametrised three-modality spatial encoder. Latches one frame of channel
// features, walks a shared channel address through the per-modality
// iM / projNeg / projPos banks, binds each non-zero feature as
// iM ^ (neg ? projNeg : projPos) and bundles each modality with per-bit
// majority counters. Ties break towards the first non-zero channel's binding.
//
// Optional feature (macro FUSED_OUT_EN): adds HypervectorFused_DO, the
// registered bitwise 3-input majority of the three modality outputs.
//
// Ports
//   Clk_CI             clock
//   Reset_RI           async reset, active-high
//   ValidIn_SI         input frame valid
//   ReadyOut_SO        encoder accepts a frame (idle)
//   ChannelsInput_DI   features, channel j at [CH_W*j +: CH_W], modality 1 first
//   ModEn_SI           per-modality enable, sampled with the frame
//   SramAddr_DO        channel index within each modality, shared by all banks
//   SramReq_SO         address valid / bank request
//   SramValid_SI       per-modality bank data valid
//   IM_DI              item memory words, modality m at [HV_DIM*m +: HV_DIM]
//   ProjNeg_DI         negative projection words, same packing
//   ProjPos_DI         positive projection words, same packing
//   ValidOut_SO        result valid
//   ReadyIn_SI         downstream ready
//   HypervectorOut_DO  per-modality bundled hypervectors, registered
//   HypervectorFused_DO (FUSED_OUT_EN only) fused majority hypervector
// -----------------------------------------------------------------------------
module spatial_encoder_param #(
  parameter int unsigned HV_DIM = 2000,
  parameter int unsigned CH_W   = 8,
  parameter int unsigned CH1    = 32,
  parameter int unsigned CH2    = 77,
  parameter int unsigned CH3    = 105,
  localparam int unsigned CH_TOT = CH1 + CH2 + CH3,
  localparam int unsigned CH_MAX = (CH1 > CH2) ? ((CH1 > CH3) ? CH1 : CH3)
                                               : ((CH2 > CH3) ? CH2 : CH3),
  localparam int unsigned ADDR_W = (CH_MAX > 1) ? $clog2(CH_MAX) : 1,
  localparam int unsigned CNT_W  = $clog2(CH_MAX + 1)
) (
  input  logic                     Clk_CI,
  input  logic                     Reset_RI,
  input  logic                     ValidIn_SI,
  output logic                     ReadyOut_SO,
  input  logic [CH_W*CH_TOT-1:0]   ChannelsInput_DI,
  input  logic [2:0]               ModEn_SI,
  output logic [ADDR_W-1:0]        SramAddr_DO,
  output logic                     SramReq_SO,
  input  logic [2:0]               SramValid_SI,
  input  logic [3*HV_DIM-1:0]      IM_DI,
  input  logic [3*HV_DIM-1:0]      ProjNeg_DI,
  input  logic [3*HV_DIM-1:0]      ProjPos_DI,
  output logic                     ValidOut_SO,
  input  logic                     ReadyIn_SI,
  output logic [3*HV_DIM-1:0]      HypervectorOut_DO
`ifdef FUSED_OUT_EN
  ,
  output logic [HV_DIM-1:0]        HypervectorFused_DO
`endif
);

  localparam int unsigned IDX_W = (CH_TOT > 1) ? $clog2(CH_TOT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic                    req_q, req_d;
  logic                    accept_c, fin_c, zero_fin_c;
  logic                    step_c, last_c;
  logic [2:0]              live_c;
  logic [CNT_W-1:0]        ch_max_en_c;
  logic [ADDR_W-1:0]       addr_q;
  logic [2:0]              en_q;
  logic [CH_W-1:0]         feat_q [CH_TOT];
  logic [2:0][HV_DIM-1:0]  out_nxt_c;
  logic [2:0][HV_DIM-1:0]  hv_q;

  // Longest enabled modality sets the number of address steps.
  always_comb begin
    ch_max_en_c = '0;
    if (en_q[0] && (CNT_W'(CH1) > ch_max_en_c)) ch_max_en_c = CNT_W'(CH1);
    if (en_q[1] && (CNT_W'(CH2) > ch_max_en_c)) ch_max_en_c = CNT_W'(CH2);
    if (en_q[2] && (CNT_W'(CH3) > ch_max_en_c)) ch_max_en_c = CNT_W'(CH3);
  end

  // A step waits only on banks of modalities still walking their channels.
  assign step_c     = (state_q == S_RUN) && ((SramValid_SI | ~live_c) == 3'b111);
  assign last_c     = (CNT_W'(addr_q) + CNT_W'(1)) == ch_max_en_c;
  assign zero_fin_c = accept_c && (ModEn_SI == 3'b000);

  // FSM next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    fin_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ValidIn_SI) begin
          accept_c = 1'b1;
          state_d  = (ModEn_SI == 3'b000) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (step_c && last_c) begin
          fin_c   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (ReadyIn_SI) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_DONE);
    req_d   = (state_d == S_RUN);
  end

  // FSM state and handshake output registers.
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  // Frame buffer, enables and shared channel address.
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      addr_q <= '0;
      en_q   <= '0;
      for (int unsigned j = 0; j < CH_TOT; j++) feat_q[j] <= '0;
    end else if (accept_c) begin
      addr_q <= '0;
      en_q   <= ModEn_SI;
      for (int unsigned j = 0; j < CH_TOT; j++) feat_q[j] <= ChannelsInput_DI[CH_W*j +: CH_W];
    end else if (step_c) begin
      addr_q <= last_c ? '0 : addr_q + ADDR_W'(1);
    end
  end

  for (genvar m = 0; m < 3; m++) begin : g_mod
    localparam int unsigned CHM = (m == 0) ? CH1 : ((m == 1) ? CH2 : CH3);
    localparam int unsigned OFF = (m == 0) ? 0 : ((m == 1) ? CH1 : CH1 + CH2);

    logic [CH_W-1:0]   feat_c;
    logic [HV_DIM-1:0] im_c, neg_c, pos_c, bind_c;
    logic [HV_DIM-1:0] tie_q, tie_d, out_c;
    logic [CNT_W-1:0]  nz_q, nz_d;
    logic [CNT_W-1:0]  cnt_q [HV_DIM];
    logic [CNT_W-1:0]  cnt_d [HV_DIM];
    logic              hit_c;

    assign im_c  = IM_DI[HV_DIM*m +: HV_DIM];
    assign neg_c = ProjNeg_DI[HV_DIM*m +: HV_DIM];
    assign pos_c = ProjPos_DI[HV_DIM*m +: HV_DIM];

    assign live_c[m] = en_q[m] && (CNT_W'(addr_q) < CNT_W'(CHM));
    // Index pinned to the modality's first channel when not live, so it stays in range.
    assign feat_c = feat_q[IDX_W'(OFF) + (live_c[m] ? IDX_W'(addr_q) : IDX_W'(0))];

    assign bind_c = im_c ^ (feat_c[CH_W-1] ? neg_c : pos_c);
    // Zero features are skipped entirely: no count, no NZ increment, no tie capture.
    assign hit_c  = step_c && live_c[m] && (feat_c != '0);
    assign nz_d   = nz_q + CNT_W'(hit_c);
    assign tie_d  = (hit_c && (nz_q == '0)) ? bind_c : tie_q;

    always_comb begin
      for (int unsigned k = 0; k < HV_DIM; k++) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(hit_c & bind_c[k]);
      end
    end

    // Majority with tie-break; evaluated on post-step values so the last channel counts.
    always_comb begin
      logic [CNT_W:0] twice;
      twice = '0;
      out_c = '0;
      for (int unsigned k = 0; k < HV_DIM; k++) begin
        twice = {cnt_d[k], 1'b0};
        if (en_q[m] && (nz_d != '0)) begin
          if (twice > {1'b0, nz_d})       out_c[k] = 1'b1;
          else if (twice == {1'b0, nz_d}) out_c[k] = tie_d[k];
        end
      end
    end

    assign out_nxt_c[m] = out_c;

    // Per-modality bundling accumulators.
    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
      if (Reset_RI) begin
        nz_q  <= '0;
        tie_q <= '0;
        for (int unsigned k = 0; k < HV_DIM; k++) cnt_q[k] <= '0;
      end else if (accept_c) begin
        nz_q  <= '0;
        tie_q <= '0;
        for (int unsigned k = 0; k < HV_DIM; k++) cnt_q[k] <= '0;
      end else if (hit_c) begin
        nz_q  <= nz_d;
        tie_q <= tie_d;
        for (int unsigned k = 0; k < HV_DIM; k++) cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Result registers: written only when a frame finalises.
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      hv_q <= '0;
    end else if (zero_fin_c) begin
      hv_q <= '0;
    end else if (fin_c) begin
      hv_q <= out_nxt_c;
    end
  end

`ifdef FUSED_OUT_EN
  logic [HV_DIM-1:0] fused_q;

  // Bitwise majority across modalities; disabled modalities already read as 0.
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      fused_q <= '0;
    end else if (zero_fin_c) begin
      fused_q <= '0;
    end else if (fin_c) begin
      fused_q <= (out_nxt_c[0] & out_nxt_c[1]) |
                 (out_nxt_c[0] & out_nxt_c[2]) |
                 (out_nxt_c[1] & out_nxt_c[2]);
    end
  end

  assign HypervectorFused_DO = fused_q;
`endif

  assign ReadyOut_SO       = ready_q;
  assign ValidOut_SO       = valid_q;
  assign SramReq_SO        = req_q;
  assign SramAddr_DO       = addr_q;
  assign HypervectorOut_DO = hv_q;

endmodule

// File: tb/tb_spatial_encoder_param.sv
module tb_spatial_encoder_param;

  localparam int unsigned HV = 8;
  localparam int unsigned CW = 4;

  logic        clk;
  logic        rst;
  logic        ValidIn_SI;
  logic        ReadyOut_SO;
  logic [35:0] ChannelsInput_DI;
  logic [2:0]  ModEn_SI;
  logic [1:0]  SramAddr_DO;
  logic        SramReq_SO;
  logic [2:0]  SramValid_SI;
  logic [23:0] IM_DI, ProjNeg_DI, ProjPos_DI;
  logic        ValidOut_SO;
  logic        ReadyIn_SI;
  logic [23:0] hv;
`ifdef FUSED_OUT_EN
  logic [7:0]  fused;
`endif

  // Bank contents per modality and channel index.
  logic [7:0] im_t  [3][4];
  logic [7:0] neg_t [3][4];
  logic [7:0] pos_t [3][4];

  int         sv_mode;   // 0: all valid, 1: random stalls, 2: forced pattern
  logic [2:0] sv_force;
  logic [2:0] sv_rnd;

  int n_cmp = 0;
  int n_mis = 0;

  spatial_encoder_param #(
    .HV_DIM(HV), .CH_W(CW), .CH1(2), .CH2(3), .CH3(4)
  ) dut (
    .Clk_CI           (clk),
    .Reset_RI         (rst),
    .ValidIn_SI       (ValidIn_SI),
    .ReadyOut_SO      (ReadyOut_SO),
    .ChannelsInput_DI (ChannelsInput_DI),
    .ModEn_SI         (ModEn_SI),
    .SramAddr_DO      (SramAddr_DO),
    .SramReq_SO       (SramReq_SO),
    .SramValid_SI     (SramValid_SI),
    .IM_DI            (IM_DI),
    .ProjNeg_DI       (ProjNeg_DI),
    .ProjPos_DI       (ProjPos_DI),
    .ValidOut_SO      (ValidOut_SO),
    .ReadyIn_SI       (ReadyIn_SI),
    .HypervectorOut_DO(hv)
`ifdef FUSED_OUT_EN
    ,
    .HypervectorFused_DO(fused)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: banks answer the shared address combinationally.
  always_comb begin
    IM_DI = '0;
    ProjNeg_DI = '0;
    ProjPos_DI = '0;
    for (int m = 0; m < 3; m++) begin
      IM_DI[8*m +: 8]      = im_t[m][SramAddr_DO];
      ProjNeg_DI[8*m +: 8] = neg_t[m][SramAddr_DO];
      ProjPos_DI[8*m +: 8] = pos_t[m][SramAddr_DO];
    end
  end

  always @(posedge clk) begin
    sv_rnd <= {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
  end

  assign SramValid_SI = (sv_mode == 0) ? 3'b111 : ((sv_mode == 1) ? sv_rnd : sv_force);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: majority bundling computed channel by channel from the rules.
  function automatic logic [23:0] model_hv(input logic [35:0] ch, input logic [2:0] en);
    logic [23:0]       res;
    logic [7:0]        tie, b;
    logic signed [3:0] f;
    int                off, n, nz;
    int                cnt [8];
    res = '0;
    for (int m = 0; m < 3; m++) begin
      off = (m == 0) ? 0 : ((m == 1) ? 2 : 5);
      n   = (m == 0) ? 2 : ((m == 1) ? 3 : 4);
      nz  = 0;
      tie = '0;
      for (int k = 0; k < 8; k++) cnt[k] = 0;
      if (en[m]) begin
        for (int j = 0; j < n; j++) begin
          f = $signed(ch[4*(off+j) +: 4]);
          if (f != 0) begin
            b = im_t[m][j] ^ ((f < 0) ? neg_t[m][j] : pos_t[m][j]);
            if (nz == 0) tie = b;
            nz++;
            for (int k = 0; k < 8; k++) cnt[k] += int'(b[k]);
          end
        end
        if (nz != 0) begin
          for (int k = 0; k < 8; k++) begin
            if (2 * cnt[k] > nz)       res[8*m + k] = 1'b1;
            else if (2 * cnt[k] == nz) res[8*m + k] = tie[k];
          end
        end
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] model_fused(input logic [23:0] o);
    return (o[7:0] & o[15:8]) | (o[7:0] & o[23:16]) | (o[15:8] & o[23:16]);
  endfunction

  task automatic rand_tables();
    for (int m = 0; m < 3; m++)
      for (int a = 0; a < 4; a++) begin
        im_t[m][a]  = 8'($urandom);
        neg_t[m][a] = 8'($urandom);
        pos_t[m][a] = 8'($urandom);
      end
  endtask

  task automatic const_tables(input logic [7:0] im, input logic [7:0] ng, input logic [7:0] ps);
    for (int m = 0; m < 3; m++)
      for (int a = 0; a < 4; a++) begin
        im_t[m][a]  = im;
        neg_t[m][a] = ng;
        pos_t[m][a] = ps;
      end
  endtask

  function automatic logic [35:0] rand_feats();
    logic [35:0] c;
    for (int j = 0; j < 9; j++) c[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
    return c;
  endfunction

  task automatic send_frame(input logic [35:0] ch, input logic [2:0] en, output int lat);
    @(negedge clk);
    check("ready_before_frame", 64'(ReadyOut_SO), 64'd1);
    ChannelsInput_DI = ch;
    ModEn_SI = en;
    ValidIn_SI = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    ValidIn_SI = 1'b0;
    while (ValidOut_SO !== 1'b1 && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("valid_out_seen", 64'(ValidOut_SO), 64'd1);
  endtask

  task automatic release_out();
    @(negedge clk);
    ReadyIn_SI = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ReadyIn_SI = 1'b0;
    check("idle_after_release_ready", 64'(ReadyOut_SO), 64'd1);
    check("idle_after_release_valid", 64'(ValidOut_SO), 64'd0);
  endtask

  initial begin
    logic [35:0] ch;
    logic [23:0] exp;
    logic [2:0]  en;
    int          lat;
    int          guard;

    rst = 1'b1;
    ValidIn_SI = 1'b0;
    ReadyIn_SI = 1'b0;
    ChannelsInput_DI = '0;
    ModEn_SI = '0;
    sv_mode = 0;
    sv_force = 3'b111;
    const_tables(8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", 64'(ReadyOut_SO), 64'd1);
    check("rst_valid", 64'(ValidOut_SO), 64'd0);
    check("rst_req", 64'(SramReq_SO), 64'd0);
    check("rst_addr", 64'(SramAddr_DO), 64'd0);
    check("rst_hv", 64'(hv), 64'd0);
    rst = 1'b0;

    // Latency and simple positive binding
    const_tables(8'h00, 8'h3C, 8'hA5);
    ch = '0;
    ch[3:0] = 4'h1;
    ch[7:4] = 4'h1;
    exp = model_hv(ch, 3'b111);
    send_frame(ch, 3'b111, lat);
    check("latency_all_en", 64'(lat), 64'd5);
    check("mod1_a5", 64'(hv[7:0]), 64'hA5);
    check("hv_a5_frame", 64'(hv), 64'(exp));
    release_out();

    // Tie-break to first non-zero channel in modality 3
    const_tables(8'h00, 8'h00, 8'hFF);
    ch = rand_feats();
    ch[23:20] = 4'h1;
    ch[27:24] = 4'hF;
    ch[31:28] = 4'h2;
    ch[35:32] = 4'hD;
    exp = model_hv(ch, 3'b111);
    send_frame(ch, 3'b111, lat);
    check("mod3_tie", 64'(hv[23:16]), 64'hFF);
    check("hv_tie_frame", 64'(hv), 64'(exp));
    release_out();

    // Stall on modality 2 bank at addr=1
    rand_tables();
    ch = rand_feats();
    exp = model_hv(ch, 3'b111);
    @(negedge clk);
    ChannelsInput_DI = ch;
    ModEn_SI = 3'b111;
    ValidIn_SI = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ValidIn_SI = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("stall_pre_addr", 64'(SramAddr_DO), 64'd1);
    sv_mode = 2;
    sv_force = 3'b101;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_addr_hold", 64'(SramAddr_DO), 64'd1);
      check("stall_req", 64'(SramReq_SO), 64'd1);
    end
    sv_mode = 0;
    guard = 0;
    while (ValidOut_SO !== 1'b1 && guard < 50) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    check("stall_valid_out", 64'(ValidOut_SO), 64'd1);
    check("hv_stall_frame", 64'(hv), 64'(exp));
    release_out();

    // Only modality 1 enabled; other banks never valid
    rand_tables();
    ch = rand_feats();
    exp = model_hv(ch, 3'b001);
    sv_mode = 2;
    sv_force = 3'b001;
    send_frame(ch, 3'b001, lat);
    sv_mode = 0;
    check("latency_mod1_only", 64'(lat), 64'd3);
    check("mod2_off", 64'(hv[15:8]), 64'd0);
    check("mod3_off", 64'(hv[23:16]), 64'd0);
    check("hv_mod1_only", 64'(hv), 64'(exp));

    // Keep result pending with ReadyIn low; new ValidIn must be ignored
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ValidIn_SI = 1'b1;
      ChannelsInput_DI = rand_feats();
      ModEn_SI = 3'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 64'(ValidOut_SO), 64'd1);
      check("hold_ready", 64'(ReadyOut_SO), 64'd0);
      check("hold_hv", 64'(hv), 64'(exp));
    end
    ValidIn_SI = 1'b0;
    release_out();

    // Distinct single-channel modalities for the fused majority
    const_tables(8'h00, 8'h00, 8'h00);
    pos_t[0][0] = 8'hF0;
    pos_t[1][0] = 8'hCC;
    pos_t[2][0] = 8'hAA;
    ch = '0;
    ch[3:0] = 4'h1;
    ch[11:8] = 4'h1;
    ch[23:20] = 4'h1;
    send_frame(ch, 3'b111, lat);
    check("hv_fuse_inputs", 64'(hv), 64'hAACCF0);
`ifdef FUSED_OUT_EN
    check("fused_e8", 64'(fused), 64'hE8);
`endif
    release_out();

    // Asynchronous reset while walking channels
    rand_tables();
    ch = rand_feats();
    @(negedge clk);
    ChannelsInput_DI = ch;
    ModEn_SI = 3'b111;
    ValidIn_SI = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ValidIn_SI = 1'b0;
    guard = 0;
    while (SramAddr_DO !== 2'd2 && guard < 20) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    check("midrun_addr2", 64'(SramAddr_DO), 64'd2);
    rst = 1'b1;
    #1;
    check("midrun_rst_req", 64'(SramReq_SO), 64'd0);
    check("midrun_rst_ready", 64'(ReadyOut_SO), 64'd1);
    check("midrun_rst_valid", 64'(ValidOut_SO), 64'd0);
    check("midrun_rst_hv", 64'(hv), 64'd0);
    check("midrun_rst_addr", 64'(SramAddr_DO), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ch = rand_feats();
    exp = model_hv(ch, 3'b111);
    send_frame(ch, 3'b111, lat);
    check("post_reset_latency", 64'(lat), 64'd5);
    check("post_reset_hv", 64'(hv), 64'(exp));
    release_out();

    // Randomised frames, enables and bank stalls
    for (int t = 0; t < 30; t++) begin
      rand_tables();
      ch = rand_feats();
      en = ($urandom_range(0, 7) == 0) ? 3'b000 : 3'($urandom);
      exp = model_hv(ch, en);
      sv_mode = int'($urandom_range(0, 1));
      send_frame(ch, en, lat);
      check("rand_hv", 64'(hv), 64'(exp));
`ifdef FUSED_OUT_EN
      check("rand_fused", 64'(fused), 64'(model_fused(exp)));
`endif
      sv_mode = 0;
      release_out();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
